// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default sizing for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int DEF_CORE_CNT = 16;
  localparam int DEF_ADDR_WID = 32;
  localparam int DEF_DATA_WID = 32;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Rotating priority picker: first set request at or after start_i, with wrap.
module rr_pick #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);
  localparam int IW1 = IW + 1;

  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW1-1:0] sum;

  // Rotate so start_i lands at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    rot     = N'({req_i, req_i} >> start_i);
    found_o = |rot;
    off     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= IW1'(N)) sum = sum - IW1'(N);
    idx_o  = sum[IW-1:0];
    pick_o = found_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the shared memory bus with a bounded hold per grant
// and a registered beat stage toward the memory controller.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int CORE_CNT = DEF_CORE_CNT,
  parameter int ADDR_WID = DEF_ADDR_WID,
  parameter int DATA_WID = DEF_DATA_WID,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDX_WID  = $clog2(CORE_CNT)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [CORE_CNT-1:0]          req_i,
  input  logic [CORE_CNT-1:0]          req_we_i,
  input  logic [CORE_CNT*ADDR_WID-1:0] req_addr_i,
  input  logic [CORE_CNT*DATA_WID-1:0] req_data_i,
  output logic [CORE_CNT-1:0]          gnt_o,
  output logic                         mem_valid_o,
  output logic                         mem_we_o,
  output logic [ADDR_WID-1:0]          mem_addr_o,
  output logic [DATA_WID-1:0]          mem_data_o,
  output logic [IDX_WID-1:0]           owner_o,
  output logic                         busy_o
);
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam int IW1 = IDX_WID + 1;

  arb_state_e            state_q;
  logic [CORE_CNT-1:0]   gnt_q;
  logic [IDX_WID-1:0]    owner_q, rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]         hold_q;
  logic                  mem_valid_q, mem_we_q;
  logic [ADDR_WID-1:0]   mem_addr_q, sel_addr;
  logic [DATA_WID-1:0]   mem_data_q, sel_data;

  logic [IW1-1:0]        own_inc;
  logic                  own_req, accept, beat_we, hold_last, release_own;
  logic [IDX_WID-1:0]    pick_start, pick_idx;
  logic [CORE_CNT-1:0]   pick_oh;
  logic                  pick_found;

  // Release bookkeeping: next rotation start and whether the owner gives up the bus.
  always_comb begin
    own_inc = {1'b0, owner_q} + IW1'(1);
    if (own_inc == IW1'(CORE_CNT)) own_inc = '0;
    rr_ptr_d    = own_inc[IDX_WID-1:0];
    own_req     = req_i[owner_q];
    accept      = |(gnt_q & req_i);
    beat_we     = |(gnt_q & req_i & req_we_i);
    hold_last   = (hold_q == HW'(MAX_HOLD - 1));
    release_own = (state_q == ST_OWNED) && (!own_req || (accept && hold_last));
    pick_start  = (state_q == ST_IDLE) ? rr_ptr_q : rr_ptr_d;
  end

  // One-hot grant steers the beat mux, so no decode of owner_q is needed.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < CORE_CNT; i++) begin
      if (gnt_q[i]) begin
        sel_addr = req_addr_i[i*ADDR_WID +: ADDR_WID];
        sel_data = req_data_i[i*DATA_WID +: DATA_WID];
      end
    end
  end

  rr_pick #(.N(CORE_CNT), .IW(IDX_WID)) u_pick (
    .req_i   (req_i),
    .start_i (pick_start),
    .pick_o  (pick_oh),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Grant FSM: idle grants from rr_ptr, release hands over in the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      hold_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            state_q <= ST_OWNED;
            gnt_q   <= pick_oh;
            owner_q <= pick_idx;
            hold_q  <= '0;
          end
        end
        ST_OWNED: begin
          if (release_own) begin
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= '0;
            if (pick_found) begin
              gnt_q   <= pick_oh;
              owner_q <= pick_idx;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
          end else if (accept) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered beat stage; address/data keep their last value between beats.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      mem_valid_q <= accept;
      mem_we_q    <= beat_we;
      if (accept) begin
        mem_addr_q <= sel_addr;
        mem_data_q <= sel_data;
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign busy_o      = |gnt_q;
  assign owner_o     = owner_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a per-cycle reference model.
module tb_mem_bus_arbiter;
  localparam int N    = 16;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            mem_valid, mem_we, busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic [3:0]      owner;

  int n_chk = 0;
  int n_err = 0;

  int          rem  [N];
  int          seq  [N];
  logic [31:0] base [N];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.CORE_CNT(N), .ADDR_WID(AW), .DATA_WID(DW), .MAX_HOLD(MAXH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_data_i(req_data), .gnt_o(gnt),
    .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .owner_o(owner), .busy_o(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner as an int (-1 = nobody), beats sent in this tenure,
  // rotation start, and the beat the memory side should be seeing.
  typedef struct {
    int          own;
    int          beats;
    int          ptr;
    bit          v;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(mdl_t s, logic [N-1:0] r, logic [N-1:0] w,
                                    logic [N*AW-1:0] ad, logic [N*DW-1:0] da);
    mdl_t n = s;
    bit acc, rel;
    int start;
    acc  = (s.own >= 0) && r[s.own];
    n.v  = acc;
    n.we = acc && w[s.own];
    if (acc) begin
      n.a = ad[s.own*AW +: AW];
      n.d = da[s.own*DW +: DW];
    end
    rel   = (s.own >= 0) && (!r[s.own] || (acc && s.beats + 1 == MAXH));
    start = s.ptr;
    if (rel) begin
      start = (s.own + 1) % N;
      n.ptr = start;
    end
    if (s.own < 0 || rel) begin
      n.own   = -1;
      n.beats = 0;
      for (int k = 0; k < N; k++)
        if (n.own < 0 && r[(start + k) % N]) n.own = (start + k) % N;
    end else if (acc) begin
      n.beats = s.beats + 1;
    end
    return n;
  endfunction

  function automatic logic [N-1:0] onehot(int o);
    logic [N-1:0] g = '0;
    if (o >= 0) g[o] = 1'b1;
    return g;
  endfunction

  // Advance the model on the same edges the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.own <= -1; m.beats <= 0; m.ptr <= 0;
      m.v <= 1'b0; m.we <= 1'b0; m.a <= '0; m.d <= '0;
    end else begin
      m <= mdl_next(m, req, req_we, req_addr, req_data);
    end
  end

  // Compare every cycle, mid-way between active edges.
  always @(negedge clk) begin
    chk("m_gnt",  64'(gnt), 64'(onehot(m.own)));
    chk("m_busy", 64'(busy), 64'(m.own >= 0));
    if (m.own >= 0) chk("m_owner", 64'(owner), 64'(m.own));
    chk("m_valid", 64'(mem_valid), 64'(m.v));
    chk("m_we",    64'(mem_we), 64'(m.we));
    chk("m_addr",  64'(mem_addr), 64'(m.a));
    chk("m_data",  64'(mem_data), 64'(m.d));
  end

  // Cores: hold req while beats remain, present the next beat after each accept.
  task automatic drive();
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      a = base[i] + 32'(4 * seq[i]);
      req[i]    = rem[i] > 0;
      req_we[i] = (i % 2) == 1;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = a ^ 32'hA5A5_0000;
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = gnt & req;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        rem[i]--;
        seq[i]++;
      end
    end
    drive();
  endtask

  task automatic clear_cores();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      seq[i]  = 0;
      base[i] = 32'(i) << 12;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_cores();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    clear_cores();
    for (int i = 0; i < N; i++) rem[i] = 1000;
    drive();
    #1 rst_n = 1'b0;

    // Reset held with every core requesting.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_valid", 64'(mem_valid), 64'h0);
    end
    rst_n = 1'b1;

    // All 16 requesting: owners 0..15,0 in blocks of MAXH, bus never idle.
    step();
    chk("first_gnt", 64'(gnt), 64'h0001);
    for (int n = 1; n < 68; n++) begin
      step();
      chk("rr_gnt", 64'(gnt), 64'(onehot((n / MAXH) % N)));
      chk("rr_valid", 64'(mem_valid), 64'h1);
    end

    // Single requester, three write beats.
    do_reset();
    rem[5] = 3; base[5] = 32'h100;
    drive();
    step(); chk("single_gnt", 64'(gnt), 64'h0020);
    step(); chk("single_v0", 64'(mem_valid), 64'h1); chk("single_we0", 64'(mem_we), 64'h1);
            chk("single_a0", 64'(mem_addr), 64'h100);
    step(); chk("single_a1", 64'(mem_addr), 64'h104);
    step(); chk("single_a2", 64'(mem_addr), 64'h108); chk("single_gnt2", 64'(gnt), 64'h0020);
    step(); chk("single_idle", 64'(gnt), 64'h0); chk("single_busy", 64'(busy), 64'h0);
            chk("single_v3", 64'(mem_valid), 64'h0);

    // Fairness between cores 1 and 2.
    do_reset();
    rem[1] = 1000; rem[2] = 1000;
    drive();
    for (int n = 0; n < 16; n++) begin
      step();
      chk("fair_gnt", 64'(gnt), ((n / MAXH) % 2 == 0) ? 64'h0002 : 64'h0004);
      if (n > 0) chk("fair_valid", 64'(mem_valid), 64'h1);
    end

    // Sole requester past its hold limit is re-granted without a gap.
    do_reset();
    rem[9] = 6; base[9] = 32'h900;
    drive();
    step(); chk("regrant_gnt0", 64'(gnt), 64'h0200);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("regrant_gnt", 64'(gnt), 64'h0200);
      chk("regrant_valid", 64'(mem_valid), 64'h1);
      chk("regrant_addr", 64'(mem_addr), 64'(32'h900 + 32'(4 * k)));
    end
    step(); chk("regrant_idle", 64'(gnt), 64'h0);

    // Early drop by core 3 hands straight to core 7.
    do_reset();
    rem[3] = 2; base[3] = 32'h300;
    rem[7] = 3; base[7] = 32'h700;
    drive();
    step(); chk("drop_gnt3a", 64'(gnt), 64'h0008);
    step();
    step(); chk("drop_gnt3b", 64'(gnt), 64'h0008);
    step(); chk("drop_gnt7", 64'(gnt), 64'h0080);
    step(); chk("drop_v7", 64'(mem_valid), 64'h1); chk("drop_a7", 64'(mem_addr), 64'h700);
    repeat (4) step();

    // Wrap-around: owner 15 releases to 0, then 0 releases to 3.
    do_reset();
    rem[15] = 2; base[15] = 32'hF00;
    drive();
    step(); chk("wrap_gnt15", 64'(gnt), 64'h8000);
    rem[0] = 2; base[0] = 32'h40;
    rem[3] = 2; base[3] = 32'h300;
    drive();
    step(); step();
    step(); chk("wrap_gnt0", 64'(gnt), 64'h0001);
    step(); step();
    step(); chk("wrap_gnt3", 64'(gnt), 64'h0008);
    repeat (3) step();

    // Reset during core 4's third beat, after core 1 moved rr_ptr to 2.
    do_reset();
    rem[1] = 1; base[1] = 32'h1100;
    rem[4] = 5; base[4] = 32'h400;
    drive();
    step(); chk("mid_gnt1", 64'(gnt), 64'h0002);
    step();
    step(); chk("mid_gnt4", 64'(gnt), 64'h0010);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    chk("mid_rst_valid", 64'(mem_valid), 64'h0);
    chk("mid_rst_we", 64'(mem_we), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rem[1] = 1;
    drive();
    rst_n = 1'b1;
    step(); chk("mid_restart", 64'(gnt), 64'h0002);
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
